// File: rtl/adc_resp_pkg.sv
// rtl/adc_resp_pkg.sv - shared types and constants for the LTC2308 responder
package adc_resp_pkg;

    localparam int CFG_W   = 6;
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_READY,
        ST_SHIFT
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall pulses on the synced level
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/ltc2308_responder.sv
// rtl/ltc2308_responder.sv - LTC2308-compatible serial responder fed by a parallel sample source
module ltc2308_responder
    import adc_resp_pkg::*;
#(
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              adc_CONVST,
    input  logic              adc_SCK,
    input  logic              adc_SDI,
    output logic              adc_SDO,
    output logic              smp_req,
    output logic [2:0]        smp_ch,
    output logic [CFG_W-1:0]  smp_cfg,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_valid,
    output logic              err_overlap,
    output logic              err_late
);

    localparam int CNT_W = $clog2(CONV_CYCLES);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0] BITS_CFG = BIT_W'(CFG_W);
    localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(DATA_W);

    logic w_cv_lvl, w_cv_rise, w_cv_fall;
    logic w_sck_lvl, w_sck_rise, w_sck_fall;
    logic w_sdi, w_sdi_rise, w_sdi_fall;
    logic w_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cv (
        .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_async(adc_CONVST),
        .o_level(w_cv_lvl), .o_rise(w_cv_rise), .o_fall(w_cv_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_async(adc_SCK),
        .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_async(adc_SDI),
        .o_level(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );

    assign w_unused = ^{w_cv_fall, w_sck_lvl, w_sdi_rise, w_sdi_fall};

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [DATA_W-1:0]  r_result;
    logic [DATA_W-1:0]  r_sdo_sr;
    logic [CFG_W-1:0]   r_cfg_sr, r_cfg_pend, r_cfg_act, r_cfg_word;
    logic               r_pend_valid, r_smp_req;
    logic               r_cfg_valid, r_err_overlap, r_err_late;

    logic w_start, w_overlap, w_conv_done, w_rise_act, w_fall_act, w_accept;

    assign w_accept = r_smp_req & smp_valid & (r_state == ST_CONVERT);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    // CONVST rise is evaluated first so a coincident SCK edge is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_overlap   = 1'b0;
        w_conv_done = 1'b0;
        w_rise_act  = 1'b0;
        w_fall_act  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cv_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_overlap = w_cv_rise;
                if (r_cnt == '0) begin
                    w_conv_done = 1'b1;
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (w_cv_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CONVERT;
                end else if (w_sck_rise) begin
                    w_rise_act  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cv_rise) begin
                    w_start     = 1'b1;
                    w_overlap   = 1'b1;
                    w_state_nxt = ST_CONVERT;
                end else if (w_sck_rise) begin
                    w_rise_act  = 1'b1;
                end else if (w_sck_fall) begin
                    w_fall_act  = 1'b1;
                    if (r_bitcnt >= BITS_ALL) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt         <= '0;
            r_bitcnt      <= '0;
            r_result      <= '0;
            r_sdo_sr      <= '0;
            r_cfg_sr      <= '0;
            r_cfg_pend    <= '0;
            r_cfg_act     <= CFG_RESET;
            r_cfg_word    <= '0;
            r_pend_valid  <= 1'b0;
            r_smp_req     <= 1'b0;
            r_cfg_valid   <= 1'b0;
            r_err_overlap <= 1'b0;
            r_err_late    <= 1'b0;
        end else begin
            r_cfg_valid   <= 1'b0;
            r_err_overlap <= w_overlap;
            r_err_late    <= 1'b0;
            if (w_start) begin
                r_cnt     <= CNT_LOAD;
                r_bitcnt  <= '0;
                r_smp_req <= 1'b1;
                if (r_pend_valid) begin
                    r_cfg_act    <= r_cfg_pend;
                    r_pend_valid <= 1'b0;
                end
            end else if (r_state == ST_CONVERT) begin
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                if (w_accept) begin
                    r_result  <= smp_data;
                    r_smp_req <= 1'b0;
                end else if (w_conv_done && r_smp_req) begin
                    r_smp_req  <= 1'b0;
                    r_err_late <= 1'b1;
                end
                // The serializer works on a copy so a late source replays the old sample.
                if (w_conv_done) begin
                    r_bitcnt <= '0;
                    r_sdo_sr <= w_accept ? smp_data : r_result;
                end
            end
            if (w_rise_act) begin
                if (r_bitcnt < BITS_CFG) r_cfg_sr <= {r_cfg_sr[CFG_W-2:0], w_sdi};
                if (r_bitcnt == BITS_CFG - BIT_W'(1)) begin
                    r_cfg_pend   <= {r_cfg_sr[CFG_W-2:0], w_sdi};
                    r_cfg_word   <= {r_cfg_sr[CFG_W-2:0], w_sdi};
                    r_pend_valid <= 1'b1;
                    r_cfg_valid  <= 1'b1;
                end
                if (r_bitcnt < BITS_ALL) r_bitcnt <= r_bitcnt + BIT_W'(1);
            end
            if (w_fall_act) r_sdo_sr <= {r_sdo_sr[DATA_W-2:0], 1'b0};
        end
    end

    assign adc_SDO     = ((r_state == ST_READY && !w_cv_lvl) || r_state == ST_SHIFT) ?
                         r_sdo_sr[DATA_W-1] : 1'b0;
    assign smp_req     = r_smp_req;
    assign smp_cfg     = r_smp_req ? r_cfg_act : '0;
    assign smp_ch      = r_smp_req ? {r_cfg_act[CFG_S1], r_cfg_act[CFG_S0], r_cfg_act[CFG_OS]} : 3'b000;
    assign cfg_word    = r_cfg_word;
    assign cfg_valid   = r_cfg_valid;
    assign err_overlap = r_err_overlap;
    assign err_late    = r_err_late;

endmodule
